rs_station_param: RTL

Parametrised reservation station for the Tomasulo core, successor to the fixed three-entry add/mul stations. Holds up to ENTRIES dispatched instructions, each with operand values or pending ROB tags. Wakes operands by snooping the common data bus (CDB), and issues one ready instruction per cycle to its execution unit over a valid/ready handshake. One instance sits per functional-unit class (add/sub, mul/div) between the dispatch stage and the execution units.

---
 rtl/rs_station_param.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rs_station_param.sv
// Parametrised Tomasulo reservation station: CDB wakeup, dispatch bypass, one issue per cycle.
// Optional macro RS_OLDEST_FIRST_EN selects the oldest ready entry instead of the lowest index.

module rs_station_entry #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int FUNC_W  = 4,
  parameter int CNT_W   = 2,
  parameter int AGE_MAX = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc,
  input  logic              clr,
`ifdef RS_OLDEST_FIRST_EN
  input  logic              age_inc,
  output logic [CNT_W-1:0]  age,
`endif
  input  logic [FUNC_W-1:0] wr_func,
  input  logic [TAG_W-1:0]  wr_rob,
  input  logic [DATA_W-1:0] wr_v1,
  input  logic [TAG_W-1:0]  wr_q1,
  input  logic              wr_r1,
  input  logic [DATA_W-1:0] wr_v2,
  input  logic [TAG_W-1:0]  wr_q2,
  input  logic              wr_r2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              valid,
  output logic [FUNC_W-1:0] func,
  output logic [TAG_W-1:0]  rob,
  output logic [DATA_W-1:0] v1,
  output logic              r1,
  output logic [DATA_W-1:0] v2,
  output logic              r2
);
  logic [TAG_W-1:0] q1, q2;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      func  <= '0;
      rob   <= '0;
      v1    <= '0;
      q1    <= '0;
      r1    <= 1'b0;
      v2    <= '0;
      q2    <= '0;
      r2    <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (alloc) begin
      valid <= 1'b1;
      func  <= wr_func;
      rob   <= wr_rob;
      v1    <= wr_v1;
      q1    <= wr_q1;
      r1    <= wr_r1;
      v2    <= wr_v2;
      q2    <= wr_q2;
      r2    <= wr_r2;
    end else begin
      if (clr) valid <= 1'b0;
      if (valid && !r1 && cdb_valid && q1 == cdb_tag) begin
        v1 <= cdb_data;
        r1 <= 1'b1;
      end
      if (valid && !r2 && cdb_valid && q2 == cdb_tag) begin
        v2 <= cdb_data;
        r2 <= 1'b1;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      age <= '0;
    else if (alloc && !flush)
      age <= '0;
    else if (age_inc && valid && age != CNT_W'(AGE_MAX))
      age <= age + CNT_W'(1);
  end
`endif
endmodule

module rs_station_param #(
  parameter int ENTRIES = 3,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int FUNC_W  = 4,
  parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [FUNC_W-1:0] disp_func,
  input  logic [TAG_W-1:0]  disp_rob,
  input  logic [DATA_W-1:0] disp_v1,
  input  logic [DATA_W-1:0] disp_v2,
  input  logic [TAG_W-1:0]  disp_q1,
  input  logic [TAG_W-1:0]  disp_q2,
  input  logic              disp_r1,
  input  logic              disp_r2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [FUNC_W-1:0] iss_func,
  output logic [TAG_W-1:0]  iss_rob,
  output logic [DATA_W-1:0] iss_op1,
  output logic [DATA_W-1:0] iss_op2,
  output logic [CNT_W-1:0]  count
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] v1;
    logic [TAG_W-1:0]  q1;
    logic              r1;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  q2;
    logic              r2;
  } disp_req_t;

  logic [ENTRIES-1:0]             e_valid, e_r1, e_r2, rdy, alloc, clr;
  logic [ENTRIES-1:0][FUNC_W-1:0] e_func;
  logic [ENTRIES-1:0][TAG_W-1:0]  e_rob;
  logic [ENTRIES-1:0][DATA_W-1:0] e_v1, e_v2;
  logic [IDX_W-1:0]               free_idx, sel;
  logic                           disp_fire, iss_fire, hit1, hit2;
  disp_req_t                      req;

  assign disp_ready = (count < CNT_W'(ENTRIES));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign rdy        = e_valid & e_r1 & e_r2;
  assign iss_valid  = |rdy;
  assign iss_fire   = iss_valid && iss_ready && !flush;

  // A tag broadcast in the dispatch cycle would otherwise be missed by the new entry.
  assign hit1 = !disp_r1 && cdb_valid && disp_q1 == cdb_tag;
  assign hit2 = !disp_r2 && cdb_valid && disp_q2 == cdb_tag;

  always_comb begin
    req      = '0;
    req.func = disp_func;
    req.rob  = disp_rob;
    req.q1   = disp_q1;
    req.q2   = disp_q2;
    req.r1   = disp_r1 | hit1;
    req.r2   = disp_r2 | hit2;
    req.v1   = hit1 ? cdb_data : disp_v1;
    req.v2   = hit2 ? cdb_data : disp_v2;
  end

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!e_valid[i]) free_idx = IDX_W'(i);
  end

`ifdef RS_OLDEST_FIRST_EN
  logic [ENTRIES-1:0][CNT_W-1:0] e_age;
  logic [CNT_W-1:0]              best_age;
  logic                          found;

  always_comb begin
    sel      = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < ENTRIES; i++)
      if (rdy[i] && (!found || e_age[i] > best_age)) begin
        sel      = IDX_W'(i);
        best_age = e_age[i];
        found    = 1'b1;
      end
  end
`else
  always_comb begin
    sel = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (rdy[i]) sel = IDX_W'(i);
  end
`endif

  assign iss_func = iss_valid ? e_func[sel] : '0;
  assign iss_rob  = iss_valid ? e_rob[sel]  : '0;
  assign iss_op1  = iss_valid ? e_v1[sel]   : '0;
  assign iss_op2  = iss_valid ? e_v2[sel]   : '0;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    assign alloc[g] = disp_fire && free_idx == IDX_W'(g);
    assign clr[g]   = iss_fire && sel == IDX_W'(g);

    rs_station_entry #(
      .DATA_W(DATA_W), .TAG_W(TAG_W), .FUNC_W(FUNC_W),
      .CNT_W(CNT_W), .AGE_MAX(ENTRIES - 1)
    ) u_ent (
      .clk1(clk1), .rst_n(rst_n), .flush(flush),
      .alloc(alloc[g]), .clr(clr[g]),
`ifdef RS_OLDEST_FIRST_EN
      .age_inc(disp_fire), .age(e_age[g]),
`endif
      .wr_func(req.func), .wr_rob(req.rob),
      .wr_v1(req.v1), .wr_q1(req.q1), .wr_r1(req.r1),
      .wr_v2(req.v2), .wr_q2(req.q2), .wr_r2(req.r2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid(e_valid[g]), .func(e_func[g]), .rob(e_rob[g]),
      .v1(e_v1[g]), .r1(e_r1[g]), .v2(e_v2[g]), .r2(e_r2[g])
    );
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (flush)
      count <= '0;
    else if (disp_fire && !iss_fire)
      count <= count + CNT_W'(1);
    else if (!disp_fire && iss_fire)
      count <= count - CNT_W'(1);
  end
endmodule
